// File: rtl/s_term_loopback_tester.sv
// Built-in self-test driver for the south-edge terminal loopback: drives walking-one then
// PRBS vectors southbound and checks the index-reversed northbound return.
module s_term_loopback_tester #(
  parameter int          LOOP_LATENCY = 2,
  parameter int          NUM_PATTERNS = 64,
  parameter logic [35:0] LFSR_SEED    = 36'h0_0000_0001
) (
  input  logic        UserCLK,
  input  logic        resetn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_count,
  output logic [7:0]  first_err_vec,
  output logic [35:0] first_err_mask,
  output logic [3:0]  S1BEG,
  output logic [7:0]  S2BEG,
  output logic [7:0]  S2BEGb,
  output logic [15:0] S4BEG,
  input  logic [3:0]  N1END,
  input  logic [7:0]  N2MID,
  input  logic [7:0]  N2END,
  input  logic [15:0] N4END
);

  // state  | meaning
  // IDLE   | outputs quiet, waiting for start
  // SETTLE | vector driven, waiting LOOP_LATENCY cycles for the return
  // CHECK  | compare returned wires against the driven vector
  // DONE   | results valid until the next start
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [7:0]  LAST_IDX = 8'(36 + NUM_PATTERNS - 1);
  localparam logic [3:0]  LAT_LOAD = 4'(LOOP_LATENCY - 1);
  localparam logic [35:0] SEED_EFF = (LFSR_SEED == 36'h0) ? 36'h1 : LFSR_SEED;

  logic [1:0]  r_state;
  logic [7:0]  r_idx;
  logic [3:0]  r_lat_cnt;
  logic [35:0] r_lfsr;
  logic [35:0] r_drive;
  logic [7:0]  r_err_count;
  logic [7:0]  r_first_err_vec;
  logic [35:0] r_first_err_mask;

  logic [35:0] w_ret;
  logic [35:0] w_lfsr_step;
  logic [35:0] w_next_vec;
  logic [7:0]  w_next_idx;
  logic        w_mismatch;
  logic        w_start_ok;

  // Undo the per-bundle index reversal so the return lines up with the driven vector.
  always_comb begin
    w_ret = '0;
    for (int i = 0; i < 4; i++)  w_ret[3 - i]       = N1END[i];
    for (int i = 0; i < 8; i++)  w_ret[4 + 7 - i]   = N2MID[i];
    for (int i = 0; i < 8; i++)  w_ret[12 + 7 - i]  = N2END[i];
    for (int i = 0; i < 16; i++) w_ret[20 + 15 - i] = N4END[i];
  end

  assign w_mismatch  = (w_ret != r_drive);
  assign w_lfsr_step = {r_lfsr[34:0], r_lfsr[35] ^ r_lfsr[24]};
  assign w_next_idx  = r_idx + 8'd1;
  assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  // r_lfsr always holds the PRBS vector of the current index once idx >= 36.
  always_comb begin
    w_next_vec = w_lfsr_step;
    if (w_next_idx < 8'd36) begin
      w_next_vec = 36'h1 << w_next_idx;
    end else if (w_next_idx == 8'd36) begin
      w_next_vec = r_lfsr;
    end
  end

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      r_state          <= ST_IDLE;
      r_idx            <= '0;
      r_lat_cnt        <= '0;
      r_lfsr           <= SEED_EFF;
      r_drive          <= '0;
      r_err_count      <= '0;
      r_first_err_vec  <= '0;
      r_first_err_mask <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start_ok) begin
            r_state          <= ST_SETTLE;
            r_idx            <= '0;
            r_lat_cnt        <= LAT_LOAD;
            r_lfsr           <= SEED_EFF;
            r_drive          <= 36'h1;
            r_err_count      <= '0;
            r_first_err_vec  <= '0;
            r_first_err_mask <= '0;
          end
        end
        ST_SETTLE: begin
          if (r_lat_cnt == 4'd0) begin
            r_state <= ST_CHECK;
          end else begin
            r_lat_cnt <= r_lat_cnt - 4'd1;
          end
        end
        ST_CHECK: begin
          if (w_mismatch) begin
            if (r_err_count != 8'hFF) begin
              r_err_count <= r_err_count + 8'd1;
            end
            if (r_err_count == 8'd0) begin
              r_first_err_vec  <= r_idx;
              r_first_err_mask <= r_drive ^ w_ret;
            end
          end
          if (r_idx == LAST_IDX) begin
            r_state <= ST_DONE;
            r_drive <= '0;
          end else begin
            r_state   <= ST_SETTLE;
            r_idx     <= w_next_idx;
            r_lat_cnt <= LAT_LOAD;
            r_drive   <= w_next_vec;
            if (r_idx >= 8'd36) begin
              r_lfsr <= w_lfsr_step;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy           = (r_state == ST_SETTLE) || (r_state == ST_CHECK);
  assign done           = (r_state == ST_DONE);
  assign pass           = done && (r_err_count == 8'd0);
  assign err_count      = r_err_count;
  assign first_err_vec  = r_first_err_vec;
  assign first_err_mask = r_first_err_mask;

  assign S1BEG  = r_drive[3:0];
  assign S2BEG  = r_drive[11:4];
  assign S2BEGb = r_drive[19:12];
  assign S4BEG  = r_drive[35:20];

endmodule

// File: tb/tb_s_term_loopback_tester.sv
// Scoreboard bench: a delayed loopback model (ideal, stuck wire, identity) feeds two
// tester instances; expected run results are queued at start and checked at done.
module tb_s_term_loopback_tester;

  logic UserCLK = 1'b0;
  always #5 UserCLK = ~UserCLK;

  logic resetn;
  logic start_a, start_b;
  logic busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [7:0] err_a, vec_a, err_b, vec_b;
  logic [35:0] mask_a, mask_b;
  logic [3:0] s1_a, s1_b, n1_a, n1_b;
  logic [7:0] s2_a, s2b_a, s2_b, s2b_b, n2m_a, n2e_a, n2m_b, n2e_b;
  logic [15:0] s4_a, s4_b, n4_a, n4_b;

  int mode_a, dly_a, mode_b, dly_b;   // mode: 0 ideal reversal, 1 N4END[5] stuck 0, 2 identity
  logic [35:0] sv_a, sv_b, nv_a, nv_b;
  logic [35:0] p1_a = '0, p2_a = '0, p1_b = '0, p2_b = '0;

  s_term_loopback_tester u_dut_a (
    .UserCLK(UserCLK), .resetn(resetn), .start(start_a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .first_err_vec(vec_a), .first_err_mask(mask_a),
    .S1BEG(s1_a), .S2BEG(s2_a), .S2BEGb(s2b_a), .S4BEG(s4_a),
    .N1END(n1_a), .N2MID(n2m_a), .N2END(n2e_a), .N4END(n4_a)
  );

  s_term_loopback_tester #(.LOOP_LATENCY(1), .NUM_PATTERNS(4)) u_dut_b (
    .UserCLK(UserCLK), .resetn(resetn), .start(start_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .first_err_vec(vec_b), .first_err_mask(mask_b),
    .S1BEG(s1_b), .S2BEG(s2_b), .S2BEGb(s2b_b), .S4BEG(s4_b),
    .N1END(n1_b), .N2MID(n2m_b), .N2END(n2e_b), .N4END(n4_b)
  );

  function automatic logic [35:0] loop_fn(input logic [35:0] v, input int mode);
    logic [35:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)  r[i]      = v[3 - i];
    for (int i = 0; i < 8; i++)  r[4 + i]  = v[4 + 7 - i];
    for (int i = 0; i < 8; i++)  r[12 + i] = v[12 + 7 - i];
    for (int i = 0; i < 16; i++) r[20 + i] = v[20 + 15 - i];
    if (mode == 2) r = v;
    if (mode == 1) r[25] = 1'b0;
    return r;
  endfunction

  assign sv_a = {s4_a, s2b_a, s2_a, s1_a};
  assign sv_b = {s4_b, s2b_b, s2_b, s1_b};
  always @(posedge UserCLK) begin
    p1_a <= sv_a; p2_a <= p1_a;
    p1_b <= sv_b; p2_b <= p1_b;
  end
  always_comb begin
    nv_a = loop_fn((dly_a == 1) ? p1_a : p2_a, mode_a);
    nv_b = loop_fn((dly_b == 1) ? p1_b : p2_b, mode_b);
  end
  assign n1_a = nv_a[3:0];  assign n2m_a = nv_a[11:4];  assign n2e_a = nv_a[19:12];  assign n4_a = nv_a[35:20];
  assign n1_b = nv_b[3:0];  assign n2m_b = nv_b[11:4];  assign n2e_b = nv_b[19:12];  assign n4_b = nv_b[35:20];

  typedef struct {
    int          busy_cyc;
    logic        pass;
    logic [7:0]  err;
    logic [7:0]  vec;
    logic [35:0] mask;
  } exp_t;
  exp_t sb_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent count of failing vectors for a static fault: a vector fails when
  // un-reversing the faulty return does not reproduce it.
  function automatic logic [7:0] model_errs(input int mode, input int npat);
    logic [35:0] v, lf;
    int c;
    c = 0;
    lf = 36'h1;
    for (int k = 0; k < 36 + npat; k++) begin
      if (k < 36) v = 36'h1 << k;
      else begin
        v = lf;
        lf = {lf[34:0], lf[35] ^ lf[24]};
      end
      if (loop_fn(loop_fn(v, mode), 0) != v) c++;
    end
    return 8'((c > 255) ? 255 : c);
  endfunction

  task automatic pulse_and_check(input int sel, input exp_t e, input int restart_at);
    int cyc;
    bit seen;
    exp_t x;
    logic bs, dn, ps;
    logic [7:0] er, fv;
    logic [35:0] fm, sv;
    sb_q.push_back(e);
    @(negedge UserCLK);
    if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
    cyc = 0;
    seen = 1'b0;
    for (int k = 0; k < 2000 && !seen; k++) begin
      @(negedge UserCLK);
      bs = (sel == 0) ? busy_a : busy_b;
      dn = (sel == 0) ? done_a : done_b;
      if (dn) seen = 1'b1;
      else if (bs) cyc++;
      if (sel == 0) start_a = (restart_at > 0 && cyc == restart_at && !dn);
      else start_b = (restart_at > 0 && cyc == restart_at && !dn);
    end
    start_a = 1'b0;
    start_b = 1'b0;
    if (!seen) check("done_timeout", 64'(seen), 64'd1);
    x  = sb_q.pop_front();
    bs = (sel == 0) ? busy_a : busy_b;
    ps = (sel == 0) ? pass_a : pass_b;
    er = (sel == 0) ? err_a : err_b;
    fv = (sel == 0) ? vec_a : vec_b;
    fm = (sel == 0) ? mask_a : mask_b;
    sv = (sel == 0) ? sv_a : sv_b;
    check("busy_cycles", 64'(cyc), 64'(x.busy_cyc));
    check("pass", 64'(ps), 64'(x.pass));
    check("err_count", 64'(er), 64'(x.err));
    check("first_err_vec", 64'(fv), 64'(x.vec));
    check("first_err_mask", 64'(fm), 64'(x.mask));
    check("busy_after_done", 64'(bs), 64'd0);
    check("s_quiet_in_done", 64'(sv), 64'd0);
  endtask

  task automatic check_a_zero(input string tag);
    check({tag, "_busy"}, 64'(busy_a), 64'd0);
    check({tag, "_done"}, 64'(done_a), 64'd0);
    check({tag, "_pass"}, 64'(pass_a), 64'd0);
    check({tag, "_err"}, 64'(err_a), 64'd0);
    check({tag, "_vec"}, 64'(vec_a), 64'd0);
    check({tag, "_mask"}, 64'(mask_a), 64'd0);
    check({tag, "_s"}, 64'(sv_a), 64'd0);
  endtask

  initial begin
    exp_t e;
    resetn = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    mode_a = 0; dly_a = 2; mode_b = 0; dly_b = 1;
    repeat (3) @(negedge UserCLK);
    check_a_zero("reset");
    check("reset_b_busy", 64'(busy_b), 64'd0);
    check("reset_b_s", 64'(sv_b), 64'd0);
    resetn = 1'b1;

    e = '{busy_cyc: 300, pass: 1'b1, err: 8'd0, vec: 8'd0, mask: 36'h0};
    pulse_and_check(0, e, 0);

    mode_a = 1;
    e = '{busy_cyc: 300, pass: 1'b0, err: model_errs(1, 64), vec: 8'd30, mask: 36'h0_4000_0000};
    pulse_and_check(0, e, 0);

    mode_a = 2;
    e = '{busy_cyc: 300, pass: 1'b0, err: model_errs(2, 64), vec: 8'd0, mask: 36'h9};
    pulse_and_check(0, e, 0);

    mode_a = 0;
    @(negedge UserCLK); start_a = 1'b1;
    @(negedge UserCLK); start_a = 1'b0;
    repeat (99) @(negedge UserCLK);
    check("busy_before_reset", 64'(busy_a), 64'd1);
    resetn = 1'b0;
    #1;
    check_a_zero("midrun_reset");
    @(negedge UserCLK);
    resetn = 1'b1;
    e = '{busy_cyc: 300, pass: 1'b1, err: 8'd0, vec: 8'd0, mask: 36'h0};
    pulse_and_check(0, e, 0);

    pulse_and_check(0, e, 50);

    e = '{busy_cyc: 80, pass: 1'b1, err: 8'd0, vec: 8'd0, mask: 36'h0};
    pulse_and_check(1, e, 0);
    // Two-cycle return against a one-cycle settle: each check sees the previous vector.
    dly_b = 2;
    e = '{busy_cyc: 80, pass: 1'b0, err: 8'd40, vec: 8'd0, mask: 36'h1};
    pulse_and_check(1, e, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/s_term_loopback_tester.md
Name: s_term_loopback_tester

Overview:
- Sequential built-in self-test driver for the south-edge terminal loopback. It sits in the bottom user tile row and drives that tile's southbound wire bundles (S1BEG, S2BEG, S2BEGb, S4BEG) into the terminal.
- It receives the returning northbound bundles (N1END, N2MID, N2END, N4END) and checks that the terminal turned every wire around with the required index reversal.
- Reports pass/fail, a saturating error count, and the index and bit mask of the first failing vector.

Parameters:
- LOOP_LATENCY, 2, cycles from driving a vector to sampling the returned wires; legal range 1..15.
- NUM_PATTERNS, 64, number of PRBS vectors applied after the walking-one phase; legal range 1..192.
- LFSR_SEED, 36'h0_0000_0001, first PRBS vector; a value of 0 is replaced by 1.

Ports:
- UserCLK input 1: fabric user clock.
- resetn input 1: asynchronous active-low reset.
- start input 1: single-cycle request to begin a test run.
- busy output 1: high while a run is in progress.
- done output 1: high from run completion until the next accepted start.
- pass output 1: valid while done=1; 1 means zero mismatches.
- err_count output 8: number of mismatching vectors, saturates at 255.
- first_err_vec output 8: index of the first failing vector.
- first_err_mask output 36: V xor R' for the first failing vector.
- S1BEG output 4: southbound single wires.
- S2BEG output 8: southbound double wires, begin.
- S2BEGb output 8: southbound double wires, second half.
- S4BEG output 16: southbound quad wires.
- N1END input 4: returning single wires.
- N2MID input 8: returning double wires, mid.
- N2END input 8: returning double wires, end.
- N4END input 16: returning quad wires.

Behaviour:
Clocking and reset:
- One clock, UserCLK. resetn is asynchronous and active-low.
- Reset, or resetn asserted mid-run, gives: state IDLE; busy=0, done=0, pass=0; err_count=0, first_err_vec=0, first_err_mask=0; all S* outputs=0; LFSR reloaded with the seed.

Vector packing:
- Driven vector V[35:0] = {S4BEG, S2BEGb, S2BEG, S1BEG}, with S1BEG in bits [3:0].
- Expected return, per bundle:
  - N1END[i] = S1BEG[3-i]
  - N2MID[i] = S2BEG[7-i]
  - N2END[i] = S2BEGb[7-i]
  - N4END[i] = S4BEG[15-i]
- R' is the received wires un-reversed per bundle into V order. A vector fails when R' != V.

Vector sequence:
- Total vectors: 36 + NUM_PATTERNS.
- Indices 0..35 (walking-one): V = 1 << idx.
- Indices 36 onward (PRBS): 36-bit Fibonacci LFSR, polynomial x^36 + x^25 + 1, one shift per vector. The first PRBS vector equals the seed.

FSM (IDLE, SETTLE, CHECK, DONE):
- IDLE: S* outputs = 0. On start=1, go to SETTLE on the next edge. That edge also sets idx=0, clears err_count, first_err_vec, first_err_mask and done, and sets busy=1.
- SETTLE: drive V(idx) and hold it for LOOP_LATENCY cycles, counted by a 4-bit counter.
- CHECK: one cycle, V still driven. Compare R' against V.
  - On mismatch, err_count increments (saturating at 255).
  - If this is the first mismatch, latch first_err_vec=idx and first_err_mask.
  - If idx is the last vector, go to DONE; otherwise idx+1 and return to SETTLE.
- DONE: busy=0, done=1, pass=(err_count==0), S* outputs=0. A new start goes to SETTLE exactly as from IDLE.

Other rules:
- start while busy is ignored; it neither restarts nor corrupts the run.
- Run length in busy cycles: (36 + NUM_PATTERNS) × (LOOP_LATENCY + 1). With defaults this is 300.
- Result outputs hold their values until the next accepted start or reset.

Test Plan:
- Ideal reversing loopback model with 2-cycle delay, defaults, pulse start → busy for exactly 300 cycles, then done=1, pass=1, err_count=0, first_err_mask=0.
- Loopback model with N4END[5] stuck at 0 → first_err_vec=30 (V[30] = S4BEG[10]), first_err_mask=36'h0_4000_0000, pass=0, err_count ≥ 1.
- Loopback model wired identity instead of reversed → first_err_vec=0, first_err_mask=36'h9, pass=0.
- Assert resetn low at cycle 100 of a run, then release it → all outputs 0 and state IDLE. A subsequent start completes with pass=1 after 300 cycles.
- Pulse start again at cycle 50 of a run → no restart; done still rises 300 cycles after the first start.
- LOOP_LATENCY=1, NUM_PATTERNS=4, model delay 1 → done after 80 cycles, pass=1. With model delay 2 instead → pass=0, err_count > 0.
